// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch-flush squash and EX back-pressure.
// Optional inserted-bubble statistics counter enabled by defining BUBBLE_STATS_EN.
module id_ex_hazard_reg #(
   parameter int DATA_W       = 32,
   parameter int REG_AW       = 5,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [5:0]        id_opcode,
   input  logic [2:0]        id_alu_control,
   input  logic              id_regwrite,
   input  logic              id_brnch,
   input  logic              id_imm,
   input  logic              id_lw,
   input  logic              id_sw,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [15:0]       id_imm16,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [5:0]        ex_opcode,
   output logic [2:0]        ex_alu_control,
   output logic              ex_regwrite,
   output logic              ex_brnch,
   output logic              ex_imm,
   output logic              ex_lw,
   output logic              ex_sw,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_dst,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm_ext,
   output logic              stall_id,
   output logic [15:0]       bubble_cnt
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_FLUSH,
      ST_BUBBLE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  flush_cnt_q, flush_cnt_d;

   logic [REG_AW-1:0] id_dst;
   logic              id_uses_rt;
   logic [DATA_W-1:0] id_imm_ext;
   logic              hz;
   logic              load_en;
   logic              load_bubble;
   logic              kill_ctl;

   assign id_dst     = (id_imm | id_lw) ? id_rt : id_rd;
   assign id_uses_rt = ~(id_imm | id_lw);
   assign id_imm_ext = {{(DATA_W-16){id_imm16[15]}}, id_imm16};

   // A bubble in EX never has ex_lw set, so hz cannot fire twice for one load.
   assign hz = (state_q == ST_RUN) && id_valid && ex_valid && ex_lw &&
               (ex_dst != '0) &&
               ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

   assign stall_id = rst_n & ~flush & (~ex_ready | hz);

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      load_en     = 1'b0;
      load_bubble = 1'b0;
      if (flush) begin
         load_en     = 1'b1;
         load_bubble = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = 4'(FLUSH_CYCLES - 2);
         end else begin
            state_d = ST_RUN;
         end
      end else if (!ex_ready) begin
         state_d = state_q;
      end else if (state_q == ST_FLUSH) begin
         load_en     = 1'b1;
         load_bubble = 1'b1;
         if (flush_cnt_q == '0) begin
            state_d = ST_RUN;
         end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
         end
      end else if (hz) begin
         load_en     = 1'b1;
         load_bubble = 1'b1;
         state_d     = ST_BUBBLE;
      end else begin
         load_en = 1'b1;
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Control bits are forced to 0 for bubbles and for invalid captures.
   assign kill_ctl = load_bubble | ~id_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid       <= 1'b0;
         ex_opcode      <= '0;
         ex_alu_control <= '0;
         ex_regwrite    <= 1'b0;
         ex_brnch       <= 1'b0;
         ex_imm         <= 1'b0;
         ex_lw          <= 1'b0;
         ex_sw          <= 1'b0;
         ex_rs          <= '0;
         ex_rt          <= '0;
         ex_dst         <= '0;
         ex_rs_data     <= '0;
         ex_rt_data     <= '0;
         ex_imm_ext     <= '0;
      end else if (load_en) begin
         ex_valid       <= id_valid & ~load_bubble;
         ex_opcode      <= load_bubble ? '0 : id_opcode;
         ex_alu_control <= kill_ctl ? '0 : id_alu_control;
         ex_regwrite    <= ~kill_ctl & id_regwrite;
         ex_brnch       <= ~kill_ctl & id_brnch;
         ex_imm         <= ~kill_ctl & id_imm;
         ex_lw          <= ~kill_ctl & id_lw;
         ex_sw          <= ~kill_ctl & id_sw;
         ex_rs          <= load_bubble ? '0 : id_rs;
         ex_rt          <= load_bubble ? '0 : id_rt;
         ex_dst         <= load_bubble ? '0 : id_dst;
         ex_rs_data     <= load_bubble ? '0 : id_rs_data;
         ex_rt_data     <= load_bubble ? '0 : id_rt_data;
         ex_imm_ext     <= load_bubble ? '0 : id_imm_ext;
      end
   end

`ifdef BUBBLE_STATS_EN
   logic [15:0] bubble_cnt_q;
   logic        bubble_bump;

   // A hazard bubble always squashes a valid ID op; flush bubbles count only valid ones.
   assign bubble_bump = load_en & load_bubble & id_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_q <= '0;
      end else if (bubble_bump && (bubble_cnt_q != 16'hFFFF)) begin
         bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
`else
   assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Self-checking bench for id_ex_hazard_reg: behavioural pipeline model checked every cycle
// plus directed load-use, flush, back-pressure and reset vectors with literal expectations.
module tb_id_ex_hazard_reg;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int FC = 2;

   typedef struct packed {
      logic          valid;
      logic [5:0]    opcode;
      logic [2:0]    alu;
      logic          regwrite;
      logic          brnch;
      logic          imm;
      logic          lw;
      logic          sw;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] rd;
      logic [DW-1:0] rs_data;
      logic [DW-1:0] rt_data;
      logic [15:0]   imm16;
   } instr_t;

   typedef struct packed {
      logic          valid;
      logic [5:0]    opcode;
      logic [2:0]    alu;
      logic          regwrite;
      logic          brnch;
      logic          imm;
      logic          lw;
      logic          sw;
      logic [AW-1:0] rs;
      logic [AW-1:0] rt;
      logic [AW-1:0] dst;
      logic [DW-1:0] rs_data;
      logic [DW-1:0] rt_data;
      logic [DW-1:0] imm_ext;
   } ex_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   instr_t cur = '0;
   logic fl = 1'b0;
   logic rdy = 1'b1;

   logic              ex_valid, ex_regwrite, ex_brnch, ex_imm, ex_lw, ex_sw, stall_id;
   logic [5:0]        ex_opcode;
   logic [2:0]        ex_alu_control;
   logic [AW-1:0]     ex_rs, ex_rt, ex_dst;
   logic [DW-1:0]     ex_rs_data, ex_rt_data, ex_imm_ext;
   logic [15:0]       bubble_cnt;
   ex_t               dut_ex;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   id_ex_hazard_reg #(.DATA_W(DW), .REG_AW(AW), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(cur.valid), .id_opcode(cur.opcode), .id_alu_control(cur.alu),
      .id_regwrite(cur.regwrite), .id_brnch(cur.brnch), .id_imm(cur.imm),
      .id_lw(cur.lw), .id_sw(cur.sw),
      .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
      .id_rs_data(cur.rs_data), .id_rt_data(cur.rt_data), .id_imm16(cur.imm16),
      .flush(fl), .ex_ready(rdy),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_control(ex_alu_control),
      .ex_regwrite(ex_regwrite), .ex_brnch(ex_brnch), .ex_imm(ex_imm),
      .ex_lw(ex_lw), .ex_sw(ex_sw),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext),
      .stall_id(stall_id), .bubble_cnt(bubble_cnt)
   );

   assign dut_ex = {ex_valid, ex_opcode, ex_alu_control, ex_regwrite, ex_brnch, ex_imm,
                    ex_lw, ex_sw, ex_rs, ex_rt, ex_dst, ex_rs_data, ex_rt_data, ex_imm_ext};

   // ---------------- behavioural model ----------------
   ex_t m_ex = '0;
   int  squash_left = 0;
   int  m_cnt = 0;

   function automatic ex_t capture(input instr_t i);
      ex_t e = '0;
      e.valid   = i.valid;
      e.opcode  = i.opcode;
      if (i.valid) begin
         e.alu = i.alu; e.regwrite = i.regwrite; e.brnch = i.brnch;
         e.imm = i.imm; e.lw = i.lw; e.sw = i.sw;
      end
      e.rs      = i.rs;
      e.rt      = i.rt;
      e.dst     = (i.imm || i.lw) ? i.rt : i.rd;
      e.rs_data = i.rs_data;
      e.rt_data = i.rt_data;
      e.imm_ext = 32'(signed'(i.imm16));
      return e;
   endfunction

   function automatic bit model_hz();
      bit reads_rt = !(cur.imm || cur.lw);
      return (squash_left == 0) && cur.valid && m_ex.valid && m_ex.lw && (m_ex.dst != 0) &&
             ((m_ex.dst == cur.rs) || (reads_rt && (m_ex.dst == cur.rt)));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ex = '0; squash_left = 0; m_cnt = 0;
      end else if (fl) begin
         m_ex = '0; squash_left = FC - 1;
         if (cur.valid) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      end else if (!rdy) begin
         m_ex = m_ex;
      end else if (squash_left > 0) begin
         m_ex = '0; squash_left = squash_left - 1;
         if (cur.valid) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      end else if (model_hz()) begin
         m_ex = '0;
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      end else begin
         m_ex = capture(cur);
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic exp_stall;
      logic [15:0] exp_cnt;
      exp_stall = rst_n && !fl && (!rdy || model_hz());
`ifdef BUBBLE_STATS_EN
      exp_cnt = 16'(m_cnt);
`else
      exp_cnt = 16'h0000;
`endif
      n_cmp++;
      if (dut_ex !== m_ex) begin
         n_bad++;
         $display("FAIL model_ex @%0t: got %h want %h", $time, dut_ex, m_ex);
      end
      n_cmp++;
      if (stall_id !== exp_stall) begin
         n_bad++;
         $display("FAIL model_stall @%0t: got %b want %b", $time, stall_id, exp_stall);
      end
      n_cmp++;
      if (bubble_cnt !== exp_cnt) begin
         n_bad++;
         $display("FAIL model_bcnt @%0t: got %0d want %0d", $time, bubble_cnt, exp_cnt);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   task automatic drive(input instr_t i, input logic f, input logic r);
      cur = i; fl = f; rdy = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic instr_t rtype(input logic [2:0] alu, input logic [4:0] rs, rt, rd,
                                    input logic [31:0] a, b);
      instr_t i = '0;
      i.valid = 1'b1; i.opcode = 6'h00; i.alu = alu; i.regwrite = 1'b1;
      i.rs = rs; i.rt = rt; i.rd = rd; i.rs_data = a; i.rt_data = b;
      return i;
   endfunction

   function automatic instr_t itype(input logic is_lw, input logic [4:0] rs, rt,
                                    input logic [15:0] imm16);
      instr_t i = '0;
      i.valid = 1'b1; i.opcode = is_lw ? 6'h23 : 6'h08; i.alu = 3'd2;
      i.regwrite = 1'b1; i.imm = 1'b1; i.lw = is_lw;
      i.rs = rs; i.rt = rt; i.rd = 5'd31; i.rs_data = 32'h100; i.imm16 = imm16;
      return i;
   endfunction

   initial begin
      instr_t nop = '0;
      drive(nop, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_ex_zero", 128'(dut_ex), 128'h0);
      chk("rst_stall_zero", 128'(stall_id), 128'h0);
      @(negedge clk); #1 rst_n = 1'b1;
      drive(nop, 1'b0, 1'b1);
      tick();

      // load-use: lw r5 then add r7 = r5 + r2
      drive(itype(1'b1, 5'd1, 5'd5, 16'h0004), 1'b0, 1'b1);
      tick();
      chk("lw_captured_dst", 128'(ex_dst), 128'd5);
      drive(rtype(3'd2, 5'd5, 5'd2, 5'd7, 32'h11, 32'h22), 1'b0, 1'b1);
      #1 chk("lu_stall", 128'(stall_id), 128'h1);
      tick();
      chk("lu_bubble_valid", 128'(ex_valid), 128'h0);
      #1 chk("lu_single_stall", 128'(stall_id), 128'h0);
      tick();
      chk("lu_add_valid", 128'(ex_valid), 128'h1);
      chk("lu_add_dst", 128'(ex_dst), 128'd7);
`ifdef BUBBLE_STATS_EN
      chk("lu_bubble_cnt", 128'(bubble_cnt), 128'd1);
`endif

      // lw r0 never hazards
      drive(itype(1'b1, 5'd1, 5'd0, 16'h0008), 1'b0, 1'b1);
      tick();
      drive(rtype(3'd2, 5'd0, 5'd0, 5'd3, 32'h1, 32'h2), 1'b0, 1'b1);
      #1 chk("lw_r0_no_stall", 128'(stall_id), 128'h0);
      tick();
      chk("lw_r0_next_dst", 128'(ex_dst), 128'd3);

      // addi reads only rs: rt match is not a hazard; sign extension
      drive(itype(1'b1, 5'd2, 5'd5, 16'h0000), 1'b0, 1'b1);
      tick();
      drive(itype(1'b0, 5'd3, 5'd5, 16'h8001), 1'b0, 1'b1);
      #1 chk("addi_rt_no_stall", 128'(stall_id), 128'h0);
      tick();
      chk("addi_dst_rt", 128'(ex_dst), 128'd5);
      chk("imm_sext", 128'(ex_imm_ext), 128'hFFFF8001);

      // flush squashes A and B, C captured
      drive(rtype(3'd2, 5'd1, 5'd2, 5'd10, 32'h1, 32'h2), 1'b0, 1'b1);
      tick();
      drive(rtype(3'd2, 5'd1, 5'd2, 5'd11, 32'hA, 32'hA), 1'b1, 1'b1);
      #1 chk("flush_no_stall", 128'(stall_id), 128'h0);
      tick();
      chk("flush_sq_a", 128'(ex_valid), 128'h0);
      drive(rtype(3'd2, 5'd1, 5'd2, 5'd12, 32'hB, 32'hB), 1'b0, 1'b1);
      #1 chk("flush_b_no_stall", 128'(stall_id), 128'h0);
      tick();
      chk("flush_sq_b", 128'(ex_valid), 128'h0);
      drive(rtype(3'd2, 5'd1, 5'd2, 5'd13, 32'hC, 32'hC), 1'b0, 1'b1);
      tick();
      chk("flush_c_valid", 128'(ex_valid), 128'h1);
      chk("flush_c_dst", 128'(ex_dst), 128'd13);

      // back-pressure holds a sub for three cycles
      drive(rtype(3'd6, 5'd1, 5'd2, 5'd9, 32'h55, 32'h33), 1'b0, 1'b1);
      tick();
      drive(rtype(3'd2, 5'd3, 5'd4, 5'd14, 32'h7, 32'h8), 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp_stall", 128'(stall_id), 128'h1);
         tick();
         chk("bp_hold_dst", 128'(ex_dst), 128'd9);
         chk("bp_hold_alu", 128'(ex_alu_control), 128'd6);
         chk("bp_hold_rs_data", 128'(ex_rs_data), 128'h55);
      end
      drive(rtype(3'd2, 5'd3, 5'd4, 5'd14, 32'h7, 32'h8), 1'b0, 1'b1);
      tick();
      chk("bp_release_dst", 128'(ex_dst), 128'd14);

      // flush beats ex_ready=0
      drive(rtype(3'd2, 5'd1, 5'd1, 5'd15, 32'h0, 32'h0), 1'b1, 1'b0);
      #1 chk("flush_hold_stall", 128'(stall_id), 128'h0);
      tick();
      chk("flush_hold_bubble", 128'(ex_valid), 128'h0);
      drive(rtype(3'd2, 5'd1, 5'd1, 5'd16, 32'h0, 32'h0), 1'b0, 1'b1);
      tick();
      chk("flush_hold_sq2", 128'(ex_valid), 128'h0);
      drive(nop, 1'b0, 1'b1);
      tick();

      // reset mid-FLUSH
      drive(rtype(3'd2, 5'd1, 5'd2, 5'd20, 32'h9, 32'h9), 1'b1, 1'b1);
      tick();
      drive(rtype(3'd2, 5'd1, 5'd2, 5'd17, 32'h4, 32'h5), 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("midflush_rst_ex", 128'(dut_ex), 128'h0);
      chk("midflush_rst_stall", 128'(stall_id), 128'h0);
      @(negedge clk); #1 rst_n = 1'b1;
      drive(rtype(3'd2, 5'd1, 5'd2, 5'd17, 32'h4, 32'h5), 1'b0, 1'b1);
      tick();
      chk("post_rst_run_valid", 128'(ex_valid), 128'h1);
      chk("post_rst_run_dst", 128'(ex_dst), 128'd17);

      drive(nop, 1'b0, 1'b1);
      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
